zxuno_regbus_ctrl: RTL
======================

# zxuno_regbus_ctrl

Sequencer for the ZXUNO internal register bus. It decodes Z80 I/O cycles on the address port (FC3Bh) and data port (FD3Bh), latches the selected register number, and generates the `zxuno_addr`, `zxuno_regrd` and `zxuno_regwr` strobes consumed by every register slave (scratch, master config, keymap and others). It also arbitrates the slaves' `dout`/`oe_n` returns into the single CPU read path. It sits between the Z80 bus glue and all ZXUNO register modules.

## Interface
- `ADDR_PORT`, 16'hFC3B, I/O port that selects the register number
- `DATA_PORT`, 16'hFD3B, I/O port that reads or writes the selected register
- `NSLAVES`, 8, number of register slaves on the read-return path (1..16)
- `NORESP_VAL`, 8'hFF, data returned when no slave claims a data-port read

- `clk` in 1: core clock; CPU strobes are synchronous to it
- `poweron_rst_n` in 1: reset, asynchronous, active-low
- `a` in 16: CPU address bus
- `iorq_n`, `rd_n`, `wr_n`, `m1_n` in 1 each: Z80 control strobes, active-low
- `cpu_din` in 8: CPU write data
- `cpu_dout` out 8: read data to CPU
- `cpu_oe_n` out 1: low while `cpu_dout` must drive the CPU data bus
- `zxuno_addr` out 8: latched register number
- `zxuno_regrd` out 1: register read qualifier
- `zxuno_regwr` out 1: single-cycle register write strobe
- `reg_wdata` out 8: write data, valid while `zxuno_regwr` is high
- `slave_dout` in 8*NSLAVES: slave read data, slave i at bits [8i+7:8i]
- `slave_oe_n` in NSLAVES: slave i claims the read when low

## Operation
- Decode: `io_cyc = ~iorq_n & m1_n`. Address match is a full 16-bit compare. A cycle with `rd_n` and `wr_n` both low is ignored, and no strobe is issued.
- Inputs are registered once (stage S). Cycle start is S-active while the previous S sample was inactive. This gives exactly one action per I/O cycle regardless of cycle length.
- FSM states:
  - IDLE: waiting for a cycle start.
  - ADDR_WR: latch `zxuno_addr <= cpu_din` (sampled from stage S), then go to WAIT_END.
  - DATA_WR: assert `zxuno_regwr` for 1 clk with `reg_wdata <= cpu_din` (stage S), then go to WAIT_END.
  - DATA_RD: hold `zxuno_regrd` high until the cycle ends, then return to IDLE.
  - WAIT_END: hold until S shows `iorq_n` high, then return to IDLE.
- An address-port read returns `zxuno_addr` with `cpu_oe_n` low. There is no state change and no `zxuno_regrd`.
- Data-port read arbitration, evaluated combinationally from `slave_oe_n` and registered into `cpu_dout` each clk:
  - The lowest-index slave with `slave_oe_n` low wins.
  - If no slave claims the read, `cpu_dout = NORESP_VAL` and `cpu_oe_n` stays low.
- `cpu_oe_n` is low only while S shows a matching read cycle (either port) in progress. It goes high 1 clk after S sees `iorq_n` or `rd_n` deassert.
- `zxuno_addr` persists across cycles. It changes only on an address-port write or on reset.

## Timing
- Reset values: `zxuno_addr=00h`, `zxuno_regrd=0`, `zxuno_regwr=0`, `reg_wdata=00h`, `cpu_dout=FFh`, `cpu_oe_n=1`, FSM in IDLE, S regs inactive.
- Reset is asynchronous and applies immediately mid-cycle: strobes drop at once, and any pending write is discarded. After release, a CPU cycle already in progress is not acted on, because it is not a fresh start. The next cycle start is.
- Address write: `zxuno_addr` updates at edge T+2, where T is the first edge sampling the active write.
- Data write: `zxuno_regwr` is high during cycle T+2..T+3 (exactly 1 clk), and the slave captures at edge T+3.
- Data read: `zxuno_regrd` rises at T+2. Slaves register `dout` one clk later, and `cpu_dout` is valid from T+4. The CPU read cycle must span ≥4 clk.
- Back-to-back I/O cycles separated by ≥1 clk of inactive `iorq_n` are each handled.

## Test plan
- Reset: assert `poweron_rst_n=0` mid data-read → `zxuno_regrd=0`, `cpu_oe_n=1`, `zxuno_addr=00h` immediately.
- OUT (FC3Bh),0Eh then OUT (FD3Bh),5Ah → `zxuno_addr=0Eh`, one 1-clk `zxuno_regwr` pulse with `reg_wdata=5Ah`. A long 10-clk write still produces exactly one pulse.
- IN (FD3Bh) with slave 2 `oe_n=0`/`dout=5Ah` and slave 5 `oe_n=0`/`dout=33h` → `cpu_dout=5Ah`, `cpu_oe_n=0`. With no slave claiming → `cpu_dout=FFh`.
- IN (FC3Bh) after selecting 0Eh → `cpu_dout=0Eh`, `zxuno_regrd` never asserted.
- Non-matching port FE3Bh, an `m1_n=0` cycle, and a cycle with `rd_n=wr_n=0` → no strobes, `cpu_oe_n=1`, `zxuno_addr` unchanged.

Source files
------------

// File: rtl/zxuno_regbus_ctrl.sv
// zxuno_regbus_ctrl: decodes Z80 I/O on the ZXUNO address/data ports into
// register-bus strobes and returns the winning slave's read data to the CPU.
module zxuno_regbus_ctrl #(
  parameter logic [15:0] ADDR_PORT  = 16'hFC3B,
  parameter logic [15:0] DATA_PORT  = 16'hFD3B,
  parameter int          NSLAVES    = 8,
  parameter logic [7:0]  NORESP_VAL = 8'hFF
) (
  input  logic                 clk,
  input  logic                 poweron_rst_n,
  input  logic [15:0]          a,
  input  logic                 iorq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic                 m1_n,
  input  logic [7:0]           cpu_din,
  output logic [7:0]           cpu_dout,
  output logic                 cpu_oe_n,
  output logic [7:0]           zxuno_addr,
  output logic                 zxuno_regrd,
  output logic                 zxuno_regwr,
  output logic [7:0]           reg_wdata,
  input  logic [8*NSLAVES-1:0] slave_dout,
  input  logic [NSLAVES-1:0]   slave_oe_n
);
  typedef enum logic [2:0] {IDLE, ADDR_WR, DATA_WR, DATA_RD, WAIT_END} state_t;
  state_t     state_q, state_d;
  logic       s_io_q, s_io_d, s_rd_q, s_rd_d, s_wr_q, s_wr_d;
  logic       s_ap_q, s_ap_d, s_dp_q, s_dp_d;
  logic [7:0] s_din_q, s_din_d;
  logic       prev_q, prev_d, armed_q, armed_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, dout_q, dout_d;
  logic       regrd_q, regrd_d, regwr_q, regwr_d, oe_n_q, oe_n_d;
  logic       raw_act, s_act, s_rdc, start;
  logic [7:0] arb;
  always_comb begin
    s_io_d  = ~iorq_n & m1_n;
    s_rd_d  = ~rd_n;
    s_wr_d  = ~wr_n;
    s_ap_d  = a == ADDR_PORT;
    s_dp_d  = a == DATA_PORT;
    s_din_d = cpu_din;
    raw_act = s_io_d & (s_ap_d | s_dp_d) & (s_rd_d ^ s_wr_d);
    s_act   = s_io_q & (s_ap_q | s_dp_q) & (s_rd_q ^ s_wr_q);
    s_rdc   = s_act & s_rd_q;
    // armed only after the bus has been seen idle, so a cycle straddling reset is ignored
    armed_d = armed_q | ~raw_act;
    start   = s_act & ~prev_q & armed_q;
    prev_d  = s_act;
    arb = NORESP_VAL;
    for (int i = NSLAVES - 1; i >= 0; i--)
      if (!slave_oe_n[i]) arb = slave_dout[8*i +: 8];
    dout_d  = (s_rdc & s_ap_q) ? addr_q : arb;
    oe_n_d  = ~(s_rdc & armed_q);
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    regwr_d = 1'b0;
    regrd_d = 1'b0;
    case (state_q)
      IDLE:     state_d = (start & s_wr_q) ? (s_ap_q ? ADDR_WR : DATA_WR) :
                          (start & s_dp_q) ? DATA_RD : IDLE;
      ADDR_WR: begin
        addr_d  = s_din_q;
        state_d = WAIT_END;
      end
      DATA_WR: begin
        regwr_d = 1'b1;
        wdata_d = s_din_q;
        state_d = WAIT_END;
      end
      DATA_RD: begin
        regrd_d = s_io_q & s_rd_q;
        state_d = regrd_d ? DATA_RD : IDLE;
      end
      default:  state_d = s_io_q ? WAIT_END : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge poweron_rst_n) begin
    if (!poweron_rst_n) begin
      state_q <= IDLE;
      s_io_q  <= 1'b0;
      s_rd_q  <= 1'b0;
      s_wr_q  <= 1'b0;
      s_ap_q  <= 1'b0;
      s_dp_q  <= 1'b0;
      s_din_q <= 8'h00;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      dout_q  <= 8'hFF;
      regrd_q <= 1'b0;
      regwr_q <= 1'b0;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      s_io_q  <= s_io_d;
      s_rd_q  <= s_rd_d;
      s_wr_q  <= s_wr_d;
      s_ap_q  <= s_ap_d;
      s_dp_q  <= s_dp_d;
      s_din_q <= s_din_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      regrd_q <= regrd_d;
      regwr_q <= regwr_d;
      oe_n_q  <= oe_n_d;
    end
  end
  assign cpu_dout    = dout_q;
  assign cpu_oe_n    = oe_n_q;
  assign zxuno_addr  = addr_q;
  assign zxuno_regrd = regrd_q;
  assign zxuno_regwr = regwr_q;
  assign reg_wdata   = wdata_q;
endmodule
